// File: rtl/tmds_period_encoder.sv
// N_CH-lane HDMI TMDS encoder with automatic preamble/guard sequencing and a fixed 2-cycle pipeline.
// Optional macro TMDS_DISP_MON_EN adds a sticky running-disparity monitor output (disp_err).
module tmds_period_encoder #(
    parameter int N_CH         = 3,
    parameter int PREAMBLE_LEN = 8,
    parameter int GUARD_LEN    = 2
) (
    input  logic                pxl_clk,
    input  logic                rst_n,
    input  logic [1:0]          period_req,
    input  logic [2*N_CH-1:0]   ctrl,
    input  logic [8*N_CH-1:0]   video_data,
    input  logic [4*N_CH-1:0]   island_data,
    output logic                data_ready,
    output logic [2:0]          period,
    output logic [10*N_CH-1:0]  tmds
`ifdef TMDS_DISP_MON_EN
    ,
    output logic                disp_err
`endif
);

    typedef enum logic [2:0] {
        ST_CTRL   = 3'd0,
        ST_PRE_V  = 3'd1,
        ST_GRD_V  = 3'd2,
        ST_VIDEO  = 3'd3,
        ST_PRE_I  = 3'd4,
        ST_GRD_IL = 3'd5,
        ST_ISLAND = 3'd6,
        ST_GRD_IT = 3'd7
    } state_t;

    localparam logic [3:0] PRE_LAST = 4'(PREAMBLE_LEN - 1);
    localparam logic [3:0] GRD_LAST = 4'(GUARD_LEN - 1);
    localparam logic [9:0] CTRL_00  = 10'b1101010100;
    localparam logic [9:0] GRD_A    = 10'b1011001100;
    localparam logic [9:0] GRD_B    = 10'b0100110011;

    function automatic logic [9:0] ctrl_code(input logic [1:0] c);
        logic [9:0] s;
        case (c)
            2'b00:   s = 10'b1101010100;
            2'b01:   s = 10'b0010101011;
            2'b10:   s = 10'b0101010100;
            default: s = 10'b1010101011;
        endcase
        return s;
    endfunction

    function automatic logic [9:0] terc4(input logic [3:0] d);
        logic [9:0] s;
        case (d)
            4'h0:    s = 10'b1010011100;
            4'h1:    s = 10'b1001100011;
            4'h2:    s = 10'b1011100100;
            4'h3:    s = 10'b1011100010;
            4'h4:    s = 10'b0101110001;
            4'h5:    s = 10'b0100011110;
            4'h6:    s = 10'b0110001110;
            4'h7:    s = 10'b0100111100;
            4'h8:    s = 10'b1011001100;
            4'h9:    s = 10'b0100111001;
            4'hA:    s = 10'b0110011100;
            4'hB:    s = 10'b1011000110;
            4'hC:    s = 10'b1010001110;
            4'hD:    s = 10'b1001110001;
            4'hE:    s = 10'b0101100011;
            default: s = 10'b1011000011;
        endcase
        return s;
    endfunction

    // Transition-minimising first stage of the 8b/10b video code; bit 8 = 1 means XOR chain.
    function automatic logic [8:0] qm_encode(input logic [7:0] d);
        logic [3:0] n1;
        logic       use_xnor;
        logic [8:0] q;
        n1       = 4'($countones(d));
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       s1_vid_q, s1_vid_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = 4'd0;
        case (state_q)
            ST_CTRL: begin
                if (period_req == 2'd1)      state_d = ST_PRE_V;
                else if (period_req == 2'd2) state_d = ST_PRE_I;
            end
            ST_PRE_V, ST_PRE_I: begin
                if (cnt_q == PRE_LAST) state_d = (state_q == ST_PRE_V) ? ST_GRD_V : ST_GRD_IL;
                else                   cnt_d   = cnt_q + 4'd1;
            end
            ST_GRD_V: begin
                if (cnt_q == GRD_LAST) state_d = ST_VIDEO;
                else                   cnt_d   = cnt_q + 4'd1;
            end
            ST_GRD_IL: begin
                if (cnt_q == GRD_LAST) state_d = ST_ISLAND;
                else                   cnt_d   = cnt_q + 4'd1;
            end
            ST_VIDEO: begin
                if (period_req != 2'd1) state_d = ST_CTRL;
            end
            ST_ISLAND: begin
                if (period_req != 2'd2) state_d = ST_GRD_IT;
            end
            ST_GRD_IT: begin
                if (cnt_q == GRD_LAST) state_d = ST_CTRL;
                else                   cnt_d   = cnt_q + 4'd1;
            end
            default: state_d = ST_CTRL;
        endcase
    end

    assign s1_vid_d   = (state_q == ST_VIDEO);
    assign data_ready = (state_q == ST_VIDEO) || (state_q == ST_ISLAND);
    assign period     = state_q;

    always_ff @(posedge pxl_clk) begin
        if (!rst_n) begin
            state_q  <= ST_CTRL;
            cnt_q    <= 4'd0;
            s1_vid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            s1_vid_q <= s1_vid_d;
        end
    end

`ifdef TMDS_DISP_MON_EN
    logic [N_CH-1:0] lane_err;
    logic            prev_vid_q;
    logic            disp_err_q, disp_err_d;

    assign disp_err_d = disp_err_q | (|lane_err);
    assign disp_err   = disp_err_q;

    always_ff @(posedge pxl_clk) begin
        if (!rst_n) begin
            prev_vid_q <= 1'b0;
            disp_err_q <= 1'b0;
        end else begin
            prev_vid_q <= s1_vid_q;
            disp_err_q <= disp_err_d;
        end
    end
`endif

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_lane
        // Lanes beyond 2 follow lane 1 for preamble and guard symbols.
        localparam logic [1:0] PRE_V_C = (gi == 2) ? 2'b00 : 2'b01;
        localparam logic [9:0] GRD_V_S = ((gi == 0) || (gi == 2)) ? GRD_A : GRD_B;
        localparam bit         IS_L0   = (gi == 0);

        logic [9:0]        s1_sym_q, s1_sym_d;
        logic [9:0]        tmds_q, tmds_d;
        logic signed [4:0] dcnt_q, dcnt_d;
        logic [8:0]        q_m;
        logic [3:0]        n1, n0;
        logic signed [4:0] diff;

        always_comb begin
            s1_sym_d = ctrl_code(ctrl[2*gi +: 2]);
            case (state_q)
                ST_PRE_V: if (!IS_L0) s1_sym_d = ctrl_code(PRE_V_C);
                ST_PRE_I: if (!IS_L0) s1_sym_d = ctrl_code(2'b01);
                ST_GRD_V: s1_sym_d = GRD_V_S;
                ST_GRD_IL, ST_GRD_IT: s1_sym_d = IS_L0 ? terc4({2'b11, ctrl[1:0]}) : GRD_B;
                ST_VIDEO:  s1_sym_d = {1'b0, qm_encode(video_data[8*gi +: 8])};
                ST_ISLAND: s1_sym_d = terc4(island_data[4*gi +: 4]);
                default:   s1_sym_d = ctrl_code(ctrl[2*gi +: 2]);
            endcase
        end

        assign q_m  = s1_sym_q[8:0];
        assign n1   = 4'($countones(q_m[7:0]));
        assign n0   = 4'd8 - n1;
        assign diff = $signed(5'(n1)) - $signed(5'(n0));

        // DC balancing; any non-video symbol leaves the counter at zero.
        always_comb begin
            tmds_d = s1_sym_q;
            dcnt_d = 5'sd0;
            if (s1_vid_q) begin
                if ((dcnt_q == 5'sd0) || (n1 == n0)) begin
                    tmds_d = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
                    dcnt_d = q_m[8] ? (dcnt_q + diff) : (dcnt_q - diff);
                end else if ((!dcnt_q[4] && (n1 > n0)) || (dcnt_q[4] && (n0 > n1))) begin
                    tmds_d = {1'b1, q_m[8], ~q_m[7:0]};
                    dcnt_d = dcnt_q + $signed({3'b000, q_m[8], 1'b0}) - diff;
                end else begin
                    tmds_d = {1'b0, q_m[8], q_m[7:0]};
                    dcnt_d = dcnt_q - $signed({3'b000, ~q_m[8], 1'b0}) + diff;
                end
            end
        end

        always_ff @(posedge pxl_clk) begin
            if (!rst_n) begin
                s1_sym_q <= CTRL_00;
                tmds_q   <= CTRL_00;
                dcnt_q   <= 5'sd0;
            end else begin
                s1_sym_q <= s1_sym_d;
                tmds_q   <= tmds_d;
                dcnt_q   <= dcnt_d;
            end
        end

        assign tmds[10*gi +: 10] = tmds_q;

`ifdef TMDS_DISP_MON_EN
        assign lane_err[gi] = (dcnt_q > 5'sd8) || (dcnt_q < -5'sd8)
                            || (s1_vid_q && !prev_vid_q && (dcnt_q != 5'sd0));
`endif
    end

endmodule

// File: tb/tb_tmds_period_encoder.sv
// Randomised bench for tmds_period_encoder against a symbol-level period/encoding model.
module tb_tmds_period_encoder;

    localparam int N_CH = 3;
    localparam int PRE  = 8;
    localparam int GRD  = 2;
    localparam int TW   = 10 * N_CH;

    localparam int SYM_CTRL  = 10;
    localparam int SYM_PRE_V = 11;
    localparam int SYM_PRE_I = 12;
    localparam int SYM_GRD_V = 13;
    localparam int SYM_GRD_I = 14;
    localparam int SYM_VIDEO = 15;
    localparam int SYM_TERC  = 16;

    logic                pxl_clk;
    logic                rst_n;
    logic [1:0]          period_req;
    logic [2*N_CH-1:0]   ctrl;
    logic [8*N_CH-1:0]   video_data;
    logic [4*N_CH-1:0]   island_data;
    logic                data_ready;
    logic [2:0]          period;
    logic [TW-1:0]       tmds;
`ifdef TMDS_DISP_MON_EN
    logic                disp_err;
`endif

    tmds_period_encoder #(.N_CH(N_CH), .PREAMBLE_LEN(PRE), .GUARD_LEN(GRD)) dut (
        .pxl_clk     (pxl_clk),
        .rst_n       (rst_n),
        .period_req  (period_req),
        .ctrl        (ctrl),
        .video_data  (video_data),
        .island_data (island_data),
        .data_ready  (data_ready),
        .period      (period),
        .tmds        (tmds)
`ifdef TMDS_DISP_MON_EN
        ,
        .disp_err    (disp_err)
`endif
    );

    initial pxl_clk = 1'b0;
    always #5 pxl_clk = ~pxl_clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [9:0] ctl_tab  [4]  = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
    logic [9:0] terc_tab [16] = '{10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
                                  10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
                                  10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
                                  10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
    logic [7:0] pats [3] = '{8'h00, 8'hFF, 8'h55};

    // Model state: committed future symbols, payload mode, disparity per lane, output pipeline.
    int            plan [$];
    int            payload;
    int            mcnt [N_CH];
    logic [TW-1:0] exp_q [$];
    logic [TW-1:0] reset_word;

    task automatic model_reset();
        plan.delete();
        payload = 0;
        for (int i = 0; i < N_CH; i++) mcnt[i] = 0;
        exp_q.delete();
        exp_q.push_back(reset_word);
        exp_q.push_back(reset_word);
    endtask

    task automatic model_kind(input logic [1:0] req, output int k);
        if (plan.size() > 0) begin
            k = plan.pop_front();
        end else if (payload == 1) begin
            k = SYM_VIDEO;
            if (req != 2'd1) payload = 0;
        end else if (payload == 2) begin
            k = SYM_TERC;
            if (req != 2'd2) begin
                payload = 0;
                repeat (GRD) plan.push_back(SYM_GRD_I);
            end
        end else begin
            k = SYM_CTRL;
            if (req == 2'd1) begin
                repeat (PRE) plan.push_back(SYM_PRE_V);
                repeat (GRD) plan.push_back(SYM_GRD_V);
                payload = 1;
            end else if (req == 2'd2) begin
                repeat (PRE) plan.push_back(SYM_PRE_I);
                repeat (GRD) plan.push_back(SYM_GRD_I);
                payload = 2;
            end
        end
    endtask

    task automatic video_sym(input logic [7:0] d, input int lane, output logic [9:0] s);
        logic [8:0] qm;
        int ones, xn, c;
        ones = $countones(d);
        xn = ((ones > 4) || (ones == 4 && d[0] == 1'b0)) ? 1 : 0;
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = (xn == 1) ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = (xn == 1) ? 1'b0 : 1'b1;
        ones = $countones(qm[7:0]);
        c = mcnt[lane];
        if (c == 0 || ones == 8 - ones) begin
            s = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            c = c + (qm[8] ? (2 * ones - 8) : (8 - 2 * ones));
        end else if ((c > 0 && ones > 4) || (c < 0 && ones < 4)) begin
            s = {1'b1, qm[8], ~qm[7:0]};
            c = c + 2 * int'(qm[8]) + (8 - 2 * ones);
        end else begin
            s = {1'b0, qm[8], qm[7:0]};
            c = c - 2 * (1 - int'(qm[8])) + (2 * ones - 8);
        end
        mcnt[lane] = c;
    endtask

    task automatic build_word(input int k, input logic [2*N_CH-1:0] c, input logic [8*N_CH-1:0] v,
                              input logic [4*N_CH-1:0] isl, output logic [TW-1:0] w);
        logic [9:0] s;
        for (int l = 0; l < N_CH; l++) begin
            s = ctl_tab[c[2*l +: 2]];
            case (k)
                SYM_PRE_V: if (l != 0) s = (l == 2) ? ctl_tab[0] : ctl_tab[1];
                SYM_PRE_I: if (l != 0) s = ctl_tab[1];
                SYM_GRD_V: s = (l == 0 || l == 2) ? 10'b1011001100 : 10'b0100110011;
                SYM_GRD_I: s = (l == 0) ? terc_tab[{2'b11, c[1:0]}] : 10'b0100110011;
                SYM_TERC:  s = terc_tab[isl[4*l +: 4]];
                SYM_VIDEO: video_sym(v[8*l +: 8], l, s);
                default:   s = ctl_tab[c[2*l +: 2]];
            endcase
            if (k != SYM_VIDEO) mcnt[l] = 0;
            w[10*l +: 10] = s;
        end
    endtask

    task automatic step(input logic [1:0] req, input logic [2*N_CH-1:0] c,
                        input logic [8*N_CH-1:0] v, input logic [4*N_CH-1:0] isl);
        int            k;
        logic          exp_dr;
        logic [TW-1:0] exp_now, w;
        period_req  = req;
        ctrl        = c;
        video_data  = v;
        island_data = isl;
        model_kind(req, k);
        exp_dr = (k == SYM_VIDEO) || (k == SYM_TERC);
        @(negedge pxl_clk);
        n_tests++;
        assert (data_ready === exp_dr) else begin
            n_fail++;
            $error("FAIL data_ready cyc=%0d got=%b exp=%b", cyc, data_ready, exp_dr);
        end
        exp_now = exp_q.pop_front();
        n_tests++;
        assert (tmds === exp_now) else begin
            n_fail++;
            $error("FAIL tmds cyc=%0d got=%h exp=%h", cyc, tmds, exp_now);
        end
        build_word(k, c, v, isl, w);
        exp_q.push_back(w);
        @(posedge pxl_clk);
        #1;
        cyc++;
    endtask

    task automatic reset_pulse(input int n);
        rst_n = 1'b0;
        repeat (n) @(posedge pxl_clk);
        #1;
        n_tests++;
        assert (data_ready === 1'b0) else begin
            n_fail++;
            $error("FAIL reset_ready got=%b exp=0", data_ready);
        end
        n_tests++;
        assert (tmds === reset_word) else begin
            n_fail++;
            $error("FAIL reset_tmds got=%h exp=%h", tmds, reset_word);
        end
`ifdef TMDS_DISP_MON_EN
        n_tests++;
        assert (disp_err === 1'b0) else begin
            n_fail++;
            $error("FAIL reset_disp_err got=%b exp=0", disp_err);
        end
`endif
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int len;
        logic [1:0] r;
        reset_word  = {N_CH{10'b1101010100}};
        rst_n       = 1'b0;
        period_req  = 2'd0;
        ctrl        = '0;
        video_data  = '0;
        island_data = '0;

        reset_pulse(3);

        // Video period with lane-0 pattern bytes, then back to control.
        repeat (3) step(2'd0, '0, '0, '0);
        for (int i = 0; i < 1 + PRE + GRD + 64; i++)
            step(2'd1, 6'($urandom), {16'($urandom), pats[i % 3]}, 12'($urandom));
        repeat (4) step(2'd0, 6'($urandom), 24'($urandom), 12'($urandom));

        // Data island, lane-0 nibbles counting through 0..F.
        for (int i = 0; i < 1 + PRE + GRD + 32; i++)
            step(2'd2, 6'($urandom), 24'($urandom), {8'($urandom), 4'(i - 1 - PRE - GRD)});
        repeat (5) step(2'd0, 6'($urandom), 24'($urandom), 12'($urandom));

        // Request withdrawn during the island preamble.
        step(2'd2, 6'($urandom), 24'($urandom), 12'($urandom));
        repeat (20) step(2'd0, 6'($urandom), 24'($urandom), 12'($urandom));

        // Reset pulse in the middle of a video period.
        for (int i = 0; i < 1 + PRE + GRD + 10; i++)
            step(2'd1, 6'($urandom), 24'($urandom), 12'($urandom));
        reset_pulse(1);
        repeat (4) step(2'd0, 6'($urandom), 24'($urandom), 12'($urandom));

        // Random period requests with random run lengths.
        for (int s = 0; s < 40; s++) begin
            r   = 2'($urandom);
            len = int'($urandom_range(1, 20));
            for (int i = 0; i < len; i++)
                step(r, 6'($urandom), 24'($urandom), 12'($urandom));
        end
        repeat (PRE + 2 * GRD + 4) step(2'd0, 6'($urandom), 24'($urandom), 12'($urandom));

`ifdef TMDS_DISP_MON_EN
        n_tests++;
        assert (disp_err === 1'b0) else begin
            n_fail++;
            $error("FAIL disp_err_clean got=%b exp=0", disp_err);
        end
        force dut.g_lane[0].dcnt_q = 5'sd12;
        @(posedge pxl_clk);
        #1;
        release dut.g_lane[0].dcnt_q;
        repeat (3) @(posedge pxl_clk);
        #1;
        n_tests++;
        assert (disp_err === 1'b1) else begin
            n_fail++;
            $error("FAIL disp_err_sticky got=%b exp=1", disp_err);
        end
        reset_pulse(1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
